// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID-stage CBZ/B branch resolver.
package cpu_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } stall_state_t;

  localparam int LOAD_EX_STALLS  = 2;
  localparam int LOAD_MEM_STALLS = 1;

  // Bit positions inside forward_CBZ.
  localparam int FWD_IDEX  = 1;
  localparam int FWD_EXMEM = 0;

endpackage

// File: rtl/cbz_branch_unit_if.sv
// Decode-stage bundle between the pipeline and the CBZ/B branch resolver.
interface cbz_branch_unit_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);

  logic              is_cbz;
  logic              is_b;
  logic [18:0]       imm19;
  logic [25:0]       imm26;
  logic [DATA_W-1:0] IFID_pc;
  logic [DATA_W-1:0] rf_Rd_data;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_result;
  logic [1:0]        forward_CBZ;
  logic              IDEX_MemRead;
  logic              EXMEM_MemRead;

  logic              stall;
  logic              flush_IFID;
  logic              pc_src;
  logic [DATA_W-1:0] br_target;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output is_cbz, is_b, imm19, imm26, IFID_pc, rf_Rd_data, ex_result, mem_result,
           forward_CBZ, IDEX_MemRead, EXMEM_MemRead,
    input  stall, flush_IFID, pc_src, br_target, br_count, taken_count, stall_count
  );

  modport slave (
    input  is_cbz, is_b, imm19, imm26, IFID_pc, rf_Rd_data, ex_result, mem_result,
           forward_CBZ, IDEX_MemRead, EXMEM_MemRead,
    output stall, flush_IFID, pc_src, br_target, br_count, taken_count, stall_count
  );

endinterface

// File: rtl/branch_target_adder.sv
// PC-relative target for CBZ (imm19) and B (imm26): sign-extend, scale by 4, add mod 2^DATA_W.
module branch_target_adder #(
  parameter int DATA_W = 64
) (
  input  logic              sel_cbz,
  input  logic [18:0]       imm19,
  input  logic [25:0]       imm26,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] target
);

  logic [DATA_W-1:0] off19;
  logic [DATA_W-1:0] off26;

  assign off19  = {{(DATA_W-21){imm19[18]}}, imm19, 2'b00};
  assign off26  = {{(DATA_W-28){imm26[25]}}, imm26, 2'b00};
  assign target = pc + (sel_cbz ? off19 : off26);

endmodule

// File: rtl/cbz_branch_unit.sv
// ID-stage CBZ/B resolver: forwarding mux and zero test, load-use stall FSM,
// fetch redirect and saturating branch statistics.
module cbz_branch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  cbz_branch_unit_if.slave bus
);

  stall_state_t      state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] operand;
  logic              zero;
  logic [1:0]        need;
  logic              stall_raw;
  logic              stall;
  logic              resolve;
  logic              taken;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;
  logic [CNT_W-1:0]  stall_count;

  always_comb begin
    if (bus.forward_CBZ[FWD_IDEX])
      operand = bus.ex_result;
    else if (bus.forward_CBZ[FWD_EXMEM])
      operand = bus.mem_result;
    else
      operand = bus.rf_Rd_data;
  end

  assign zero = (operand == '0);

  always_comb begin
    need = 2'd0;
    if (bus.forward_CBZ[FWD_IDEX] && bus.IDEX_MemRead)
      need = 2'(LOAD_EX_STALLS);
    else if (bus.forward_CBZ[FWD_EXMEM] && bus.EXMEM_MemRead)
      need = 2'(LOAD_MEM_STALLS);
  end

  // The first stall cycle is raised from IDLE; WAIT only covers the remaining ones,
  // and the hazard is not re-checked there because the bubbles alter forward_CBZ.
  assign stall_raw = (state == WAIT) || (bus.is_cbz && (need != 2'd0));
  assign stall     = reset && stall_raw;
  assign resolve   = reset && !stall_raw && (bus.is_cbz || bus.is_b);
  assign taken     = resolve && (bus.is_cbz ? zero : bus.is_b);

  assign bus.stall       = stall;
  assign bus.pc_src      = taken;
  assign bus.flush_IFID  = taken;
  assign bus.br_count    = br_count;
  assign bus.taken_count = taken_count;
  assign bus.stall_count = stall_count;

  branch_target_adder #(.DATA_W(DATA_W)) u_target (
    .sel_cbz (bus.is_cbz),
    .imm19   (bus.imm19),
    .imm26   (bus.imm26),
    .pc      (bus.IFID_pc),
    .target  (bus.br_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.is_cbz && (need > 2'd1)) begin
            state <= WAIT;
            cnt   <= need - 2'd1;
          end
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count    <= '0;
      taken_count <= '0;
      stall_count <= '0;
    end else begin
      if (resolve && !(&br_count))
        br_count <= br_count + CNT_W'(1);
      if (taken && !(&taken_count))
        taken_count <= taken_count + CNT_W'(1);
      if (stall && !(&stall_count))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cbz_branch_unit.sv
// Self-checking bench for cbz_branch_unit: directed plan, then random traffic against a reference model.
module tb_cbz_branch_unit;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam int SAT_W  = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  cbz_branch_unit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  cbz_branch_unit_if #(.DATA_W(DATA_W), .CNT_W(SAT_W)) sat_bus ();

  // The narrow-counter copy sees identical traffic so saturation is reachable.
  assign sat_bus.is_cbz        = bus.is_cbz;
  assign sat_bus.is_b          = bus.is_b;
  assign sat_bus.imm19         = bus.imm19;
  assign sat_bus.imm26         = bus.imm26;
  assign sat_bus.IFID_pc       = bus.IFID_pc;
  assign sat_bus.rf_Rd_data    = bus.rf_Rd_data;
  assign sat_bus.ex_result     = bus.ex_result;
  assign sat_bus.mem_result    = bus.mem_result;
  assign sat_bus.forward_CBZ   = bus.forward_CBZ;
  assign sat_bus.IDEX_MemRead  = bus.IDEX_MemRead;
  assign sat_bus.EXMEM_MemRead = bus.EXMEM_MemRead;

  cbz_branch_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  cbz_branch_unit #(.DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus.slave)
  );

  always #5 clk = ~clk;

  int          extra;
  int          m_need;
  logic [63:0] m_br, m_taken, m_stall;
  logic [63:0] s_br, s_taken, s_stall;
  logic        exp_stall, exp_pc_src, exp_resolved, exp_target_valid;
  logic [63:0] exp_target;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] bump(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (64'd1 << w) - 64'd1;
    return (v >= top) ? top : v + 64'd1;
  endfunction

  task automatic clear_model();
    extra   = 0;
    m_need  = 0;
    m_br    = '0;
    m_taken = '0;
    m_stall = '0;
    s_br    = '0;
    s_taken = '0;
    s_stall = '0;
  endtask

  task automatic apply_stimulus(input logic cbz, input logic b, input logic [18:0] i19,
                                input logic [25:0] i26, input logic [63:0] pc,
                                input logic [63:0] rf, input logic [63:0] ex,
                                input logic [63:0] mem, input logic [1:0] fwd,
                                input logic idex_mr, input logic exmem_mr);
    bus.is_cbz        = cbz;
    bus.is_b          = b;
    bus.imm19         = i19;
    bus.imm26         = i26;
    bus.IFID_pc       = pc;
    bus.rf_Rd_data    = rf;
    bus.ex_result     = ex;
    bus.mem_result    = mem;
    bus.forward_CBZ   = fwd;
    bus.IDEX_MemRead  = idex_mr;
    bus.EXMEM_MemRead = exmem_mr;
  endtask

  // Reference behaviour for the current cycle, from the branch rules directly.
  task automatic model_comb();
    logic [63:0]        opnd;
    logic signed [63:0] off;
    case (bus.forward_CBZ)
      2'b10, 2'b11: opnd = bus.ex_result;
      2'b01:        opnd = bus.mem_result;
      default:      opnd = bus.rf_Rd_data;
    endcase
    m_need = 0;
    if (bus.forward_CBZ[1] && bus.IDEX_MemRead)
      m_need = 2;
    else if (bus.forward_CBZ[0] && bus.EXMEM_MemRead)
      m_need = 1;
    if (bus.is_cbz)
      off = 64'($signed(bus.imm19));
    else
      off = 64'($signed(bus.imm26));
    exp_target       = bus.IFID_pc + 64'(off * 64'sd4);
    exp_target_valid = reset && (bus.is_cbz || bus.is_b);
    exp_stall        = 1'b0;
    exp_resolved     = 1'b0;
    exp_pc_src       = 1'b0;
    if (reset) begin
      if (extra > 0 || (bus.is_cbz && m_need > 0)) begin
        exp_stall = 1'b1;
      end else if (bus.is_cbz) begin
        exp_resolved = 1'b1;
        exp_pc_src   = (opnd == 64'd0);
      end else if (bus.is_b) begin
        exp_resolved = 1'b1;
        exp_pc_src   = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      if (exp_stall) begin
        if (extra > 0)
          extra--;
        else
          extra = m_need - 1;
        m_stall = bump(m_stall, CNT_W);
        s_stall = bump(s_stall, SAT_W);
      end
      if (exp_resolved) begin
        m_br = bump(m_br, CNT_W);
        s_br = bump(s_br, SAT_W);
      end
      if (exp_pc_src) begin
        m_taken = bump(m_taken, CNT_W);
        s_taken = bump(s_taken, SAT_W);
      end
    end
  endtask

  // Entered shortly after a negedge with inputs applied; returns on the next negedge.
  task automatic run_cycle(input string tag);
    #2;
    model_comb();
    check_output({tag, " stall"},      64'(bus.stall),      64'(exp_stall));
    check_output({tag, " pc_src"},     64'(bus.pc_src),     64'(exp_pc_src));
    check_output({tag, " flush_IFID"}, 64'(bus.flush_IFID), 64'(exp_pc_src));
    check_output({tag, " sat stall"},  64'(sat_bus.stall),  64'(exp_stall));
    if (exp_target_valid) begin
      check_output({tag, " br_target"}, bus.br_target, exp_target);
    end
    @(posedge clk);
    model_update();
    #1;
    check_output({tag, " br_count"},        64'(bus.br_count),        m_br);
    check_output({tag, " taken_count"},     64'(bus.taken_count),     m_taken);
    check_output({tag, " stall_count"},     64'(bus.stall_count),     m_stall);
    check_output({tag, " sat br_count"},    64'(sat_bus.br_count),    s_br);
    check_output({tag, " sat taken_count"}, 64'(sat_bus.taken_count), s_taken);
    check_output({tag, " sat stall_count"}, 64'(sat_bus.stall_count), s_stall);
    @(negedge clk);
  endtask

  initial begin
    logic        r_cbz, r_b;
    logic [1:0]  r_kind;
    logic [63:0] r_rf, r_ex, r_mem;

    reset = 1'b0;
    clear_model();
    apply_stimulus(1'b0, 1'b1, 19'd0, 26'd3, 64'h80, 64'd0, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_output("reset stall",       64'(bus.stall),       64'd0);
    check_output("reset pc_src",      64'(bus.pc_src),      64'd0);
    check_output("reset flush",       64'(bus.flush_IFID),  64'd0);
    check_output("reset br_count",    64'(bus.br_count),    64'd0);
    check_output("reset taken_count", 64'(bus.taken_count), 64'd0);
    check_output("reset stall_count", 64'(bus.stall_count), 64'd0);
    run_cycle("reset hold");
    reset = 1'b1;

    // CBZ on a zero register-file operand resolves taken in the same cycle.
    apply_stimulus(1'b1, 1'b0, 19'd4, 26'd0, 64'h100, 64'd0, 64'd55, 64'd66, 2'b00, 1'b0, 1'b0);
    #1;
    check_output("cbz rf pc_src", 64'(bus.pc_src),     64'd1);
    check_output("cbz rf flush",  64'(bus.flush_IFID), 64'd1);
    check_output("cbz rf target", bus.br_target,       64'h110);
    check_output("cbz rf stall",  64'(bus.stall),      64'd0);
    run_cycle("cbz rf");
    check_output("cbz rf br_count",    64'(bus.br_count),    64'd1);
    check_output("cbz rf taken_count", 64'(bus.taken_count), 64'd1);

    // Load in EX: two stall cycles, then a non-zero operand resolves not-taken.
    apply_stimulus(1'b1, 1'b0, 19'd8, 26'd0, 64'h200, 64'd5, 64'd9, 64'd0, 2'b10, 1'b1, 1'b0);
    #1;
    check_output("ldex c1 stall",  64'(bus.stall),  64'd1);
    check_output("ldex c1 pc_src", 64'(bus.pc_src), 64'd0);
    run_cycle("ldex c1");
    #1;
    check_output("ldex c2 stall", 64'(bus.stall), 64'd1);
    run_cycle("ldex c2");
    apply_stimulus(1'b1, 1'b0, 19'd8, 26'd0, 64'h200, 64'd5, 64'd9, 64'd0, 2'b00, 1'b0, 1'b0);
    #1;
    check_output("ldex c3 stall",  64'(bus.stall),  64'd0);
    check_output("ldex c3 pc_src", 64'(bus.pc_src), 64'd0);
    run_cycle("ldex c3");
    check_output("ldex stall_count", 64'(bus.stall_count), 64'd2);
    check_output("ldex br_count",    64'(bus.br_count),    64'd2);

    // Both forwarding bits set: the ID/EX value (zero) wins over MEM (7).
    apply_stimulus(1'b1, 1'b0, 19'h7FFFF, 26'd0, 64'h1000, 64'd9, 64'd0, 64'd7, 2'b11, 1'b0, 1'b0);
    #1;
    check_output("fwd prio stall",  64'(bus.stall),  64'd0);
    check_output("fwd prio pc_src", 64'(bus.pc_src), 64'd1);
    check_output("fwd prio target", bus.br_target,   64'hFFC);
    run_cycle("fwd prio");

    // Unconditional B with offset -1 from PC 0 wraps, and ignores load hazards.
    apply_stimulus(1'b0, 1'b1, 19'd0, 26'h3FFFFFF, 64'h0, 64'd1, 64'd1, 64'd1, 2'b11, 1'b1, 1'b1);
    #1;
    check_output("b wrap stall",  64'(bus.stall),  64'd0);
    check_output("b wrap pc_src", 64'(bus.pc_src), 64'd1);
    check_output("b wrap target", bus.br_target,   64'hFFFF_FFFF_FFFF_FFFC);
    run_cycle("b wrap");
    check_output("b wrap taken_count", 64'(bus.taken_count), 64'd3);

    // Reset dropped during the first load-stall cycle.
    apply_stimulus(1'b1, 1'b0, 19'd1, 26'd0, 64'h300, 64'd0, 64'd0, 64'd0, 2'b10, 1'b1, 1'b0);
    #1;
    check_output("rst mid stall before", 64'(bus.stall), 64'd1);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    check_output("rst mid stall",       64'(bus.stall),       64'd0);
    check_output("rst mid pc_src",      64'(bus.pc_src),      64'd0);
    check_output("rst mid br_count",    64'(bus.br_count),    64'd0);
    check_output("rst mid stall_count", 64'(bus.stall_count), 64'd0);
    @(posedge clk);
    #1;
    check_output("rst held stall",       64'(bus.stall),       64'd0);
    check_output("rst held stall_count", 64'(bus.stall_count), 64'd0);
    @(negedge clk);
    run_cycle("rst held");

    // Fresh CBZ with the load in MEM: exactly one stall cycle.
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, 19'd2, 26'd0, 64'h400, 64'd3, 64'd5, 64'd0, 2'b01, 1'b0, 1'b1);
    #1;
    check_output("ldmem c1 stall", 64'(bus.stall), 64'd1);
    run_cycle("ldmem c1");
    apply_stimulus(1'b1, 1'b0, 19'd2, 26'd0, 64'h400, 64'd0, 64'd5, 64'd3, 2'b00, 1'b0, 1'b0);
    #1;
    check_output("ldmem c2 stall",  64'(bus.stall),  64'd0);
    check_output("ldmem c2 pc_src", 64'(bus.pc_src), 64'd1);
    check_output("ldmem c2 target", bus.br_target,   64'h408);
    run_cycle("ldmem c2");
    check_output("ldmem stall_count", 64'(bus.stall_count), 64'd1);

    // Eight taken B's push the 3-bit counters to all-ones and hold them there.
    apply_stimulus(1'b0, 1'b1, 19'd0, 26'd1, 64'h500, 64'd0, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_cycle("sat b");
    end
    check_output("sat br_count all-ones",    64'(sat_bus.br_count),    64'd7);
    check_output("sat taken_count all-ones", 64'(sat_bus.taken_count), 64'd7);
    check_output("wide br_count",            64'(bus.br_count),        64'd9);
    check_output("wide taken_count",         64'(bus.taken_count),     64'd9);

    for (int i = 0; i < 300; i++) begin
      r_kind = 2'($urandom_range(0, 3));
      r_cbz  = (r_kind == 2'd1) || (r_kind == 2'd2);
      r_b    = (r_kind == 2'd3);
      r_rf   = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()};
      r_ex   = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()};
      r_mem  = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()};
      apply_stimulus(r_cbz, r_b, 19'($urandom()), 26'($urandom()), {$urandom(), $urandom()},
                     r_rf, r_ex, r_mem, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
